// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions used by the rotate amount finder: FSM state
// encoding and the default datapath word width.
package cpu_pkg;

    localparam int unsigned CPU_XLEN = 32;

    typedef enum logic [1:0] {
        ROTF_IDLE   = 2'd0,
        ROTF_SEARCH = 2'd1,
        ROTF_DONE   = 2'd2
    } rotf_state_e;

endpackage

// File: rtl/rotate_amount_finder_rol1_step.sv
// Combinational single-position left rotate of a WIDTH-bit vector; the MSB
// wraps into the LSB.
module rol1_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout
);

    assign o_dout = {i_din[WIDTH-2:0], i_din[WIDTH-1]};

endmodule

// File: rtl/rotate_amount_finder.sv
// Multi-cycle search for the smallest left-rotate amount mapping a onto target.
// Build option: define ROT_FIND_EARLY_EXIT_EN to leave SEARCH on the first match;
// otherwise every search runs all WIDTH compares (constant latency).
module rotate_amount_finder
    import cpu_pkg::*;
#(
    // Must be a power of two >= 2.
    parameter  int WIDTH = CPU_XLEN,
    localparam int AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] target,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic [AMT_W-1:0] amount
);

    localparam logic [AMT_W-1:0] K_LAST = AMT_W'(WIDTH - 1);

    rotf_state_e      r_state;
    logic [WIDTH-1:0] r_rot;
    logic [WIDTH-1:0] r_tgt;
    logic [AMT_W-1:0] r_k;
    logic             r_hit;
    logic [AMT_W-1:0] r_amount;
    logic             r_busy;
    logic             r_done;

    logic [WIDTH-1:0] w_rot_next;
    logic             w_match;
    logic             w_last;

    rol1_step #(
        .WIDTH (WIDTH)
    ) u_rol1_step (
        .i_din  (r_rot),
        .o_dout (w_rot_next)
    );

    assign w_match = (r_rot == r_tgt);
    // Exit is decoded before the increment, so k never needs to wrap.
    assign w_last  = (r_k == K_LAST);

    // NOTE: every register here, datapath included, is cleared by clr so an
    // aborted search leaves no stale rot/tgt/k behind; all updates use <= so
    // each edge sees the previous cycle's values regardless of statement order.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state  <= ROTF_IDLE;
            r_rot    <= '0;
            r_tgt    <= '0;
            r_k      <= '0;
            r_hit    <= 1'b0;
            r_amount <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                ROTF_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_rot    <= a;
                        r_tgt    <= target;
                        r_k      <= '0;
                        r_hit    <= 1'b0;
                        r_amount <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= ROTF_SEARCH;
                    end
                end

                ROTF_SEARCH: begin
                    // Only the first match is recorded; later ones never overwrite it.
                    if (w_match && !r_hit) begin
                        r_hit    <= 1'b1;
                        r_amount <= r_k;
                    end
`ifdef ROT_FIND_EARLY_EXIT_EN
                    if (w_match || w_last) begin
`else
                    if (w_last) begin
`endif
                        r_done  <= 1'b1;
                        r_state <= ROTF_DONE;
                    end else begin
                        r_rot <= w_rot_next;
                        r_k   <= r_k + AMT_W'(1);
                    end
                end

                ROTF_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ROTF_IDLE;
                end

                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ROTF_IDLE;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign found  = r_hit;
    assign amount = r_amount;

endmodule

// File: tb/tb_rotate_amount_finder.sv
// Scoreboard bench for rotate_amount_finder: directed plus random searches are
// predicted by a reference model and checked by an independent done monitor.
module tb_rotate_amount_finder;

    localparam int W  = 32;
    localparam int AW = $clog2(W);

    logic          clk = 1'b0;
    logic          clr;
    logic          start;
    logic [W-1:0]  a;
    logic [W-1:0]  target;
    logic          busy;
    logic          done;
    logic          found;
    logic [AW-1:0] amount;

    always #5 clk = ~clk;

    rotate_amount_finder #(
        .WIDTH (W)
    ) dut (
        .clk    (clk),
        .clr    (clr),
        .start  (start),
        .a      (a),
        .target (target),
        .busy   (busy),
        .done   (done),
        .found  (found),
        .amount (amount)
    );

    typedef struct {
        logic f;
        int   amt;
        int   t0;
        int   lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] rotl(input logic [W-1:0] v, input int k);
        logic [2*W-1:0] d;
        d = {v, v} << k;
        return d[2*W-1:W];
    endfunction

    // Reference: scan every amount in ascending order, first hit wins.
    function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] tv);
        exp_t e;
        e.f   = 1'b0;
        e.amt = 0;
        e.t0  = 0;
        for (int k = 0; k < W; k++) begin
            if (!e.f && rotl(av, k) == tv) begin
                e.f   = 1'b1;
                e.amt = k;
            end
        end
`ifdef ROT_FIND_EARLY_EXIT_EN
        e.lat = e.f ? e.amt + 1 : W;
`else
        e.lat = W;
`endif
        return e;
    endfunction

    // Monitor: pops the scoreboard on every done pulse, checks result hold while idle.
    logic last_f    = 1'b0;
    int   last_amt  = 0;
    logic prev_done = 1'b0;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!clr) begin
                last_f    = 1'b0;
                last_amt  = 0;
                prev_done = 1'b0;
            end else if (done) begin
                check("done_single_cycle", {31'd0, prev_done}, 32'd0);
                check("busy_with_done", {31'd0, busy}, 32'd1);
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL spurious_done: got done pulse, want none (t=%0t)", $time);
                end else begin
                    e = sb.pop_front();
                    check("found", {31'd0, found}, {31'd0, e.f});
                    check("amount", 32'(amount), 32'(e.amt));
                    check("latency", 32'(cyc - e.t0), 32'(e.lat));
                    last_f   = e.f;
                    last_amt = e.amt;
                end
                prev_done = 1'b1;
            end else begin
                prev_done = 1'b0;
                if (!busy) begin
                    check("hold_found", {31'd0, found}, {31'd0, last_f});
                    check("hold_amount", 32'(amount), 32'(last_amt));
                end
            end
        end
    end

    task automatic run(input logic [W-1:0] av, input logic [W-1:0] tv, input bit extra_start);
        int   waitc;
        exp_t e;
        waitc = 0;
        @(negedge clk);
        while ((busy || done) && waitc < 200) begin
            @(negedge clk);
            waitc++;
        end
        if (waitc >= 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL idle_timeout: got busy after %0d cycles, want idle", waitc);
            return;
        end
        a      = av;
        target = tv;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        a      = $urandom;
        target = $urandom;
        e      = model(av, tv);
        e.t0   = cyc;
        sb.push_back(e);
        if (extra_start) begin
            repeat (4) @(posedge clk);
            #1 start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
        end
    endtask

    task automatic run_random();
        logic [W-1:0] av;
        logic [W-1:0] tv;
        logic [3:0]   nib;
        case ($urandom_range(2, 0))
            0: begin
                av = $urandom;
                tv = rotl(av, $urandom_range(W - 1, 0));
            end
            1: begin
                av = $urandom;
                tv = $urandom;
            end
            default: begin
                nib = 4'($urandom);
                av  = {8{nib}};
                tv  = rotl(av, $urandom_range(W - 1, 0));
            end
        endcase
        run(av, tv, 1'b0);
    endtask

    initial begin
        int waitc;
        clr    = 1'b1;
        start  = 1'b0;
        a      = '0;
        target = '0;
        #2 clr = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_found", {31'd0, found}, 32'd0);
        check("rst_amount", 32'(amount), 32'd0);
        #1 clr = 1'b1;

        run(32'h0000_0001, 32'h0000_0010, 1'b0);
        run(32'h8000_0000, 32'h0000_0001, 1'b0);
        run(32'h0000_0000, 32'h0000_0000, 1'b0);
        run(32'hAAAA_AAAA, 32'h5555_5555, 1'b0);
        run(32'h0000_0001, 32'h0000_0003, 1'b1);

        for (int i = 0; i < 30; i++) run_random();

        // Abort a search mid-flight, then confirm a fresh search is clean.
        run(32'h0000_0001, 32'h0010_0000, 1'b0);
        repeat (9) @(posedge clk);
        #2;
        check("busy_before_clr", {31'd0, busy}, 32'd1);
        clr = 1'b0;
        #1;
        check("clr_busy", {31'd0, busy}, 32'd0);
        check("clr_done", {31'd0, done}, 32'd0);
        check("clr_found", {31'd0, found}, 32'd0);
        check("clr_amount", 32'(amount), 32'd0);
        sb.delete();
        @(negedge clk);
        #1 clr = 1'b1;
        run(32'h0000_0002, 32'h0000_0008, 1'b0);

        for (int i = 0; i < 10; i++) run_random();

        waitc = 0;
        while (sb.size() != 0 && waitc < 200) begin
            @(negedge clk);
            waitc++;
        end
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d results outstanding, want 0", sb.size());
        end
        repeat (40) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rotate_amount_finder.md
# rotate_amount_finder

Multi-cycle inverse of the datapath rotate-left operation. Given an operand `a` and a `target`, the block searches for the smallest amount `k` in 0..WIDTH-1 such that rotating `a` left by `k` equals `target`. It then reports `found` and `amount` under a start/done handshake. It sits beside the ALU shift/rotate units and serves as a diagnostic/verification engine for the rotate path.

## Interface
- `WIDTH`, default 32: operand width; must be a power of two ≥ 2.
- `AMT_W`, localparam, $clog2(WIDTH): width of the amount field.
- `clk` in 1: rising-edge clock.
- `clr` in 1: reset, asynchronous, active-low.
- `start` in 1: request a search; sampled only in IDLE.
- `a` in WIDTH: operand to rotate; captured on the accepting edge.
- `target` in WIDTH: value to match; captured on the accepting edge.
- `busy` out 1: high in SEARCH and DONE.
- `done` out 1: one-cycle pulse; result valid.
- `found` out 1: a match exists.
- `amount` out AMT_W: smallest matching left-rotate amount; 0 when not found.

## Operation
- States are IDLE, SEARCH and DONE.
- **IDLE:** on a rising edge with `start`=1:
  - Load `rot` = `a` and `tgt` = `target`.
  - Set `k` = 0 and clear `found`, `amount` and the internal hit flag.
  - Go to SEARCH.
- **SEARCH:** each edge compares `rot` with `tgt` at the current `k`.
  - On the first equality: latch `found`=1 and `amount`=`k`. Later matches never overwrite it.
  - Otherwise: `rot` ← rotate `rot` left by 1, and `k` ← `k`+1.
  - Exit to DONE on the first match (early-exit build), or when `k` = WIDTH-1 has been compared.
- **DONE:** `done`=1 for exactly one cycle, then return to IDLE.
- `found` and `amount` hold their values until the next accepted start.
- `start` while `busy` is ignored and does not queue.
- Inputs `a` and `target` may change freely after the accepting edge.
- Periodic operands (e.g. all-zero, 0xAAAAAAAA) report the smallest `k`.
- No match after all WIDTH positions gives `found`=0 and `amount`=0.
- `k` is AMT_W bits wide and never wraps: the SEARCH exit is decoded at `k` = WIDTH-1 before increment.
- **Reset:** `clr` low at any time, including mid-SEARCH, forces IDLE asynchronously.
  - `busy`=0, `done`=0, `found`=0, `amount`=0.
  - `rot`, `tgt` and `k` are cleared.

## Timing
- The start edge is E0.
- Early-exit build, match at `k`: the DONE transition is on edge E(k+1), and `done` is high during cycle k+1 after E0.
  - Total latency is k+1 cycles, range 1..WIDTH.
- No match, or non-early-exit build: `done` is high WIDTH cycles after E0.
- `busy` rises the cycle after E0 and falls the cycle after `done`.
- The earliest next start is accepted on the edge after DONE, giving back-to-back searches with a one-cycle gap.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- Macro: `ROT_FIND_EARLY_EXIT_EN`.
- **Defined:** SEARCH leaves on the first match, so latency is data-dependent (k+1).
- **Undefined:** constant-time operation; SEARCH always runs all WIDTH compares.
  - The result still records the first (smallest) match.
  - `done` is always WIDTH cycles after the start edge.

## Structure
- Shared package `cpu_pkg` holds:
  - The state enum (`ROTF_IDLE`, `ROTF_SEARCH`, `ROTF_DONE`).
  - The default word width constant (32).
- Sub-module `rol1_step`: combinational single-bit left rotate of a WIDTH vector.
  - Instantiated once on the `rot` feedback path.
- The remainder is a single FSM plus datapath registers.

## Test plan
- `a`=0x00000001, `target`=0x00000010, early-exit build → `found`=1, `amount`=4, `done` 5 cycles after start; constant-time build → same result, `done` at 32.
- `a`=0x80000000, `target`=0x00000001 → `found`=1, `amount`=1 (wrap of the MSB into the LSB).
- `a`=0x00000000, `target`=0x00000000 → `found`=1, `amount`=0, `done` 1 cycle after start (early exit); `a`=0xAAAAAAAA, `target`=0x55555555 → `amount`=1, the smallest of 16 matches.
- `a`=0x00000001, `target`=0x00000003 → `found`=0, `amount`=0, `done` 32 cycles after start; a second `start` pulse at cycle 5 is ignored, with only one `done` pulse.
- Start a search expected to reach `amount`=20, drive `clr` low at cycle 10 → all outputs 0 immediately; after release, a new search with `a`=0x00000002, `target`=0x00000008 returns `amount`=2.
- Back-to-back: start accepted the cycle after `done` → the second result is correct and the first result holds until that accept.
